// File: rtl/ripple_borrow_subtractor_2_stage_pkg.sv
// Shared constants for the two-stage ripple-borrow subtractor.
package ripple_borrow_subtractor_2_stage_pkg;

  localparam int unsigned RBS_WIDTH = 4;
  localparam int unsigned RBS_HALF  = RBS_WIDTH / 2;

endpackage

// File: rtl/ripple_borrow_subtractor_2_stage_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/ripple_borrow_subtractor_2_stage.sv
// Two-stage pipelined subtractor: low half rippled in stage 1, high half in stage 2,
// valid/ready handshake on both sides with a one-deep skid in stage 1.
module ripple_borrow_subtractor_2_stage
  import ripple_borrow_subtractor_2_stage_pkg::*;
#(
  parameter int unsigned WIDTH = RBS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [HALF-1:0] lo_diff;
  logic [HALF:0]   lo_brw;
  logic [HALF-1:0] hi_diff;
  logic [HALF:0]   hi_brw;

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_lo_q, s1_lo_d;
  logic            s1_borrow_q, s1_borrow_d;
  logic [HALF-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HALF-1:0] s1_b_hi_q, s1_b_hi_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic            bout_q, bout_d;

  logic            s2_adv;
  logic            s1_adv;

  // Borrow chains: stage 1 on live operands, stage 2 on the registered upper halves.
  assign lo_brw[0] = bin;
  assign hi_brw[0] = s1_borrow_q;

  for (genvar i = 0; i < HALF; i++) begin : g_bits
    full_subtractor u_fs_lo (
      .x  (a[i]),
      .y  (b[i]),
      .bi (lo_brw[i]),
      .d  (lo_diff[i]),
      .bo (lo_brw[i+1])
    );
    full_subtractor u_fs_hi (
      .x  (s1_a_hi_q[i]),
      .y  (s1_b_hi_q[i]),
      .bi (hi_brw[i]),
      .d  (hi_diff[i]),
      .bo (hi_brw[i+1])
    );
  end

  // Stage 1 may also fill while stage 2 is stalled, provided it is empty.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_ready    = !rst && s1_adv;

    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_borrow_d = s1_borrow_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_lo_d     = lo_diff;
        s1_borrow_d = lo_brw[HALF];
        s1_a_hi_d   = a[WIDTH-1:HALF];
        s1_b_hi_d   = b[WIDTH-1:HALF];
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = {hi_diff, s1_lo_q};
        bout_d = hi_brw[HALF];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_borrow_q <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_borrow_q <= s1_borrow_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_borrow_subtractor_2_stage.sv
// Directed and exhaustive checks of the two-stage subtractor with a scoreboard on the output side.
module tb_ripple_borrow_subtractor_2_stage;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         bin, in_valid, in_ready;
  logic [W-1:0] diff;
  logic         bout, out_valid, out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;
  logic [4:0] sb_q[$];

  ripple_borrow_subtractor_2_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: negedge values equal what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          chk("sb_result", int'({bout, diff}), int'(sb_q.pop_front()));
          n_pop++;
        end
      end
      if (in_valid && in_ready) begin
        int d;
        logic [4:0] e;
        d = int'(a) - int'(b) - int'(bin);
        e[4]   = (d < 0);
        e[3:0] = 4'(d & 15);
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] a, b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t basic[5] = '{
    '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0},
    '{4'd1,  4'd1,  1'b1, 4'd15, 1'b1},
    '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1},
    '{4'd14, 4'd5,  1'b1, 4'd8,  1'b0},
    '{4'd5,  4'd14, 1'b0, 4'd7,  1'b1}
  };
  vec_t b2b[5] = '{
    '{4'd3,  4'd1,  1'b0, 4'd2,  1'b0},
    '{4'd9,  4'd9,  1'b0, 4'd0,  1'b0},
    '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1},
    '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0},
    '{4'd8,  4'd8,  1'b1, 4'd15, 1'b1}
  };
  vec_t bp[3] = '{
    '{4'd7,  4'd2,  1'b0, 4'd5,  1'b0},
    '{4'd2,  4'd7,  1'b0, 4'd11, 1'b1},
    '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0}
  };

  initial begin
    int idx, k, pop0;
    logic acc;
    logic [4:0] got_r[3];

    rst = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Single operations with latency check.
    foreach (basic[i]) begin
      a = basic[i].a; b = basic[i].b; bin = basic[i].bin; in_valid = 1'b1;
      chk("basic_in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("basic_lat1_valid", int'(out_valid), 0);
      tick();
      chk("basic_lat2_valid", int'(out_valid), 1);
      chk("basic_diff", int'(diff), int'(basic[i].diff));
      chk("basic_bout", int'(bout), int'(basic[i].bout));
      tick();
    end

    // Back-to-back stream.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        a = b2b[i].a; b = b2b[i].b; bin = b2b[i].bin; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) chk("b2b_first_empty", int'(out_valid), 0);
      else begin
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_diff", int'(diff), int'(b2b[i-1].diff));
        chk("b2b_bout", int'(bout), int'(b2b[i-1].bout));
      end
    end
    tick();
    chk("b2b_drained", int'(out_valid), 0);

    // Backpressure: only two operations fit while the output is stalled.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      a = bp[idx].a; b = bp[idx].b; bin = bp[idx].bin; in_valid = 1'b1;
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (c >= 2) begin
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_diff", int'(diff), 5);
        chk("bp_hold_bout", int'(bout), 0);
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      if (idx < 3) begin
        a = bp[idx].a; b = bp[idx].b; bin = bp[idx].bin; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        got_r[k] = {bout, diff};
        k++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_result_count", k, 3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", int'(got_r[i]), int'({bp[i].bout, bp[i].diff}));
    tick(); tick();

    // Reset with two operations in flight.
    a = 4'd4; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
    tick();
    a = 4'd6; b = 4'd2;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_bout", int'(bout), 0);
    chk("midrst_in_ready_after", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_stale", int'(out_valid), 0);
    end

    // Exhaustive sweep with random valid and ready.
    pop0 = n_pop;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      a = vv[8:5]; b = vv[4:1]; bin = vv[0];
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && in_ready;
        tick();
      end
      if (!acc) chk("ex_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ex_queue_empty", sb_q.size(), 0);
    chk("ex_result_count", n_pop - pop0, 512);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
